// File: rtl/memory_arbiter_if.sv
// Memory-side bus of the two-requester memory arbiter.
// The arbiter uses the master modport and the memory model uses the slave modport.
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  mem_valid;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_write_data;
  logic [3:0]            mem_write_mask;
  logic [31:0]           mem_read_data;
  logic                  mem_ack;

  modport master (
    output mem_valid,
    output mem_write,
    output mem_address,
    output mem_write_data,
    output mem_write_mask,
    input  mem_read_data,
    input  mem_ack
  );

  modport slave (
    input  mem_valid,
    input  mem_write,
    input  mem_address,
    input  mem_write_data,
    input  mem_write_mask,
    output mem_read_data,
    output mem_ack
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter for the single memory port, with an ack watchdog and a one-cycle completion pulse.
// Define ARBITER_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r0_read_enable,
  input  logic                  r0_write_enable,
  input  logic [ADDR_WIDTH-1:0] r0_address,
  input  logic [31:0]           r0_write_data,
  input  logic [3:0]            r0_write_mask,
  output logic [31:0]           r0_read_data,
  output logic                  r0_data_available,
  output logic                  r0_error,
  input  logic                  r1_read_enable,
  input  logic                  r1_write_enable,
  input  logic [ADDR_WIDTH-1:0] r1_address,
  input  logic [31:0]           r1_write_data,
  input  logic [3:0]            r1_write_mask,
  output logic [31:0]           r1_read_data,
  output logic                  r1_data_available,
  output logic                  r1_error,
  memory_arbiter_if.master      mem
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W:0]  LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  load;
  logic                  capture;
  logic                  timed_out;
  logic                  req0;
  logic                  req1;
  logic                  grant;
  logic                  owner;
  logic                  op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            mask_q;
  logic [31:0]           rdata_q;
  logic                  error_q;
  logic [CNT_W-1:0]      count;
  logic                  limit_next;

  assign req0 = r0_read_enable | r0_write_enable;
  assign req1 = r1_read_enable | r1_write_enable;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the requester that was not served last time wins.
  assign grant = (req0 && req1) ? ~last_grant : req1;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (load) begin
      last_grant <= grant;
    end
  end
`else
  assign grant = ~req0;
`endif

  // The current ACCESS cycle is the last one allowed before the watchdog fires.
  assign limit_next = (({1'b0, count} + 1'b1) == LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          load       = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (limit_next) begin
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner    <= 1'b0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      count    <= '0;
    end else begin
      if (load) begin
        owner    <= grant;
        op_write <= grant ? r1_write_enable : r0_write_enable;
        addr_q   <= grant ? r1_address : r0_address;
        wdata_q  <= grant ? r1_write_data : r0_write_data;
        mask_q   <= (grant ? r1_write_enable : r0_write_enable)
                    ? (grant ? r1_write_mask : r0_write_mask) : 4'b0000;
        error_q  <= 1'b0;
        count    <= '0;
      end else if (state == ACCESS) begin
        if ({1'b0, count} != LIMIT) begin
          count <= count + 1'b1;
        end
        if (capture) begin
          rdata_q <= mem.mem_read_data;
          error_q <= 1'b0;
        end else if (timed_out) begin
          rdata_q <= '0;
          error_q <= 1'b1;
        end
      end
    end
  end

  // Bus fields and responses are forced to zero outside their own state.
  assign mem.mem_valid      = (state == ACCESS);
  assign mem.mem_write      = (state == ACCESS) & op_write;
  assign mem.mem_address    = (state == ACCESS) ? addr_q  : '0;
  assign mem.mem_write_data = (state == ACCESS) ? wdata_q : '0;
  assign mem.mem_write_mask = (state == ACCESS) ? mask_q  : '0;

  assign r0_data_available = (state == RESP) & ~owner;
  assign r1_data_available = (state == RESP) &  owner;
  assign r0_read_data      = r0_data_available ? rdata_q : '0;
  assign r1_read_data      = r1_data_available ? rdata_q : '0;
  assign r0_error          = r0_data_available & error_q;
  assign r1_error          = r1_data_available & error_q;

endmodule
